// File: rtl/mem_store_unit.sv
// ---------------------------------------------------------------------------
// mem_store_unit
//   Store-data path from the MEM stage to an external asynchronous SRAM.
//   Stores pick their write data from one of NSRC operand sources (or zero),
//   are queued with their address in a DEPTH-entry FIFO, and are drained to
//   SRAM by a SETUP / WE-pulse / HOLD sequencer. Queued stores are forwarded
//   combinationally to loads.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   st_valid/ready  : store handshake from the MEM stage
//   st_addr         : store word address
//   src_data        : packed operand sources, source i at [i*DATA_W +: DATA_W]
//   src_sel         : source index, values >= NSRC select zero
//   ld_addr         : current load address for forwarding
//   fwd_hit/data    : youngest queued store matching ld_addr (data 0 on miss)
//   sram_addr       : SRAM address
//   sram_data_o     : SRAM write data
//   sram_data_oe    : write-data tristate enable
//   sram_we_n       : SRAM write enable, active low
//   drained         : FIFO empty and sequencer idle
// ---------------------------------------------------------------------------
module mem_store_unit #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 18,
    parameter int NSRC      = 2,
    parameter int SEL_W     = 2,
    parameter int DEPTH     = 4,
    parameter int PULSE_CYC = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [ADDR_W-1:0]      st_addr,
    input  logic [NSRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]       src_sel,
    input  logic [ADDR_W-1:0]      ld_addr,
    output logic                   fwd_hit,
    output logic [DATA_W-1:0]      fwd_data,
    output logic [ADDR_W-1:0]      sram_addr,
    output logic [DATA_W-1:0]      sram_data_o,
    output logic                   sram_data_oe,
    output logic                   sram_we_n,
    output logic                   drained
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;
    localparam int PCW   = $clog2(PULSE_CYC + 1);
    localparam logic [PCW-1:0] PC_LAST = PCW'(PULSE_CYC);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [ADDR_W-1:0] r_addr_mem [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [1:0]        r_state;
    logic [PCW-1:0]    r_pcnt;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0] r_sram_data;
    logic              r_oe;
    logic              r_we_n;

    logic [DATA_W-1:0] w_sel_data;
    logic              w_push;
    logic              w_pop;
    logic [PW-1:0]     w_rd_nxt;

    // Source mux; unmatched select values fall through to zero.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_sel == SEL_W'(i))
                w_sel_data = src_data[i*DATA_W +: DATA_W];
        end
    end

    // st_ready comes from the registered count only, so a pop in the same
    // cycle cannot open a slot early.
    assign st_ready = (r_count < CNT_W'(DEPTH));
    assign w_push   = st_valid && st_ready;
    assign w_pop    = (r_state == S_HOLD);
    assign w_rd_nxt = r_rd_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_mem[r_wr_ptr] <= st_addr;
            r_data_mem[r_wr_ptr] <= w_sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= w_rd_nxt;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Write sequencer. Address/data are loaded only on entry to SETUP, so
    // they stay stable across SETUP, PULSE and HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pcnt      <= '0;
            r_sram_addr <= '0;
            r_sram_data <= '0;
            r_oe        <= 1'b0;
            r_we_n      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state     <= S_SETUP;
                        r_sram_addr <= r_addr_mem[r_rd_ptr];
                        r_sram_data <= r_data_mem[r_rd_ptr];
                        r_oe        <= 1'b1;
                    end
                end
                S_SETUP: begin
                    r_state <= S_PULSE;
                    r_we_n  <= 1'b0;
                    r_pcnt  <= PCW'(1);
                end
                S_PULSE: begin
                    if (r_pcnt == PC_LAST) begin
                        r_state <= S_HOLD;
                        r_we_n  <= 1'b1;
                    end else begin
                        r_pcnt <= r_pcnt + PCW'(1);
                    end
                end
                S_HOLD: begin
                    // Head is popped this edge; chain straight into the next
                    // entry if one is already queued behind it.
                    if (r_count > CNT_W'(1)) begin
                        r_state     <= S_SETUP;
                        r_sram_addr <= r_addr_mem[w_rd_nxt];
                        r_sram_data <= r_data_mem[w_rd_nxt];
                    end else begin
                        r_state <= S_IDLE;
                        r_oe    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_we_n  <= 1'b1;
                    r_oe    <= 1'b0;
                end
            endcase
        end
    end

    // Forwarding: walk oldest to youngest so the youngest match wins. The
    // head stays visible while it is being written, until its pop edge.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < r_count) &&
                (r_addr_mem[r_rd_ptr + PW'(k)] == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_data_mem[r_rd_ptr + PW'(k)];
            end
        end
    end

    assign sram_addr    = r_sram_addr;
    assign sram_data_o  = r_sram_data;
    assign sram_data_oe = r_oe;
    assign sram_we_n    = r_we_n;
    assign drained      = (r_count == '0) && (r_state == S_IDLE);

endmodule
